// File: rtl/sale_terminal_pkg.sv
// Shared constants, FSM state type and character encoders for the sale-terminal barcode transmitter.
// Frame length constants cover both builds (BARCODE_TX_CHECKSUM_EN adds one checksum byte).
package sale_terminal_pkg;

    localparam logic [7:0] ASCII_B     = 8'h42;
    localparam logic [7:0] ASCII_X     = 8'h78;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_QMARK = 8'h3F;

    localparam logic [3:0] FRAME_BYTES_BASE = 4'd9;
    localparam logic [3:0] FRAME_BYTES_CSUM = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT,
        LAST
    } tx_state_t;

    // Non-BCD digit values are flagged as '?' rather than silently mis-encoded.
    function automatic logic [7:0] digit_ascii(input logic [3:0] d);
        return (d > 4'd9) ? ASCII_QMARK : {4'h3, d};
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] v);
        return (v > 4'd9) ? (8'h37 + {4'h0, v}) : {4'h3, v};
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, each held DIV clocks.
// ready is also high in the final stop-bit cycle so the next byte can follow with no gap.
module uart_tx_byte #(
    parameter int DIV = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready
);

    localparam int             CW        = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]  BAUD_LAST = CW'(DIV - 1);

    logic          active;
    logic [3:0]    bit_cnt;
    logic [CW-1:0] baud_cnt;
    logic [9:0]    shreg;
    logic          bit_end;

    assign bit_end = (baud_cnt == BAUD_LAST);
    assign ready   = !active || (bit_end && (bit_cnt == 4'd9));
    assign tx      = active ? shreg[0] : 1'b1;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active   <= 1'b0;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
        end else if (load && ready) begin
            active   <= 1'b1;
            bit_cnt  <= 4'd0;
            baud_cnt <= '0;
        end else if (active) begin
            if (bit_end) begin
                baud_cnt <= '0;
                if (bit_cnt == 4'd9) begin
                    active <= 1'b0;
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                end
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end
        end
    end

    // Shift register carries the whole 10-bit symbol; idle line level comes from active.
    always_ff @(posedge clock) begin
        if (load && ready) begin
            shreg <= {1'b1, data, 1'b0};
        end else if (active && bit_end) begin
            shreg <= {1'b1, shreg[9:1]};
        end
    end

endmodule

// File: rtl/barcode_uart_tx.sv
// Sends "B<d3><d2><d1><d0>x<Q>\r\n" over a UART line on each accepted Start.
// Define BARCODE_TX_CHECKSUM_EN to insert a hex XOR checksum character before CR.
module barcode_uart_tx
    import sale_terminal_pkg::*;
#(
    parameter int CLK_HZ = 50000000,
    parameter int BAUD   = 115200
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic       Start,
    input  logic [3:0] Barcode_Digit_0,
    input  logic [3:0] Barcode_Digit_1,
    input  logic [3:0] Barcode_Digit_2,
    input  logic [3:0] Barcode_Digit_3,
    input  logic [3:0] ProductQuantity,
    output logic       TX,
    output logic       Busy,
    output logic       Done
);

    localparam int DIV = CLK_HZ / BAUD;
`ifdef BARCODE_TX_CHECKSUM_EN
    localparam logic [3:0] LAST_IDX = FRAME_BYTES_CSUM - 4'd1;
`else
    localparam logic [3:0] LAST_IDX = FRAME_BYTES_BASE - 4'd1;
`endif

    tx_state_t  state, state_nxt;
    logic [3:0] byte_idx, byte_idx_nxt;
    logic [3:0] load_idx;
    logic [7:0] load_byte;
    logic       load;
    logic       done_nxt;
    logic       tx_ready;
    logic [3:0] dig3, dig2, dig1, dig0, qty;

    assign Busy = (state != IDLE);

    // Byte 0 is a constant, so the frame can start in the same edge that latches the inputs.
    always_ff @(posedge CLOCK_50) begin
        if ((state == IDLE) && Start) begin
            dig3 <= Barcode_Digit_3;
            dig2 <= Barcode_Digit_2;
            dig1 <= Barcode_Digit_1;
            dig0 <= Barcode_Digit_0;
            qty  <= ProductQuantity;
        end
    end

    always_comb begin
        load_byte = ASCII_B;
        case (load_idx)
            4'd1:    load_byte = digit_ascii(dig3);
            4'd2:    load_byte = digit_ascii(dig2);
            4'd3:    load_byte = digit_ascii(dig1);
            4'd4:    load_byte = digit_ascii(dig0);
            4'd5:    load_byte = ASCII_X;
            4'd6:    load_byte = hex_ascii(qty);
`ifdef BARCODE_TX_CHECKSUM_EN
            4'd7:    load_byte = hex_ascii(dig3 ^ dig2 ^ dig1 ^ dig0 ^ qty);
            4'd8:    load_byte = ASCII_CR;
            4'd9:    load_byte = ASCII_LF;
`else
            4'd7:    load_byte = ASCII_CR;
            4'd8:    load_byte = ASCII_LF;
`endif
            default: load_byte = ASCII_B;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state    <= IDLE;
            byte_idx <= 4'd0;
            Done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            byte_idx <= byte_idx_nxt;
            Done     <= done_nxt;
        end
    end

    // SEND marks the first cycle of a freshly issued byte; the next byte is loaded from WAIT
    // in the final stop-bit cycle of the current one.
    always_comb begin
        state_nxt    = state;
        byte_idx_nxt = byte_idx;
        load         = 1'b0;
        load_idx     = byte_idx + 4'd1;
        done_nxt     = 1'b0;
        case (state)
            IDLE: begin
                load_idx = 4'd0;
                if (Start) begin
                    load         = 1'b1;
                    byte_idx_nxt = 4'd0;
                    state_nxt    = SEND;
                end
            end
            SEND: state_nxt = (byte_idx == LAST_IDX) ? LAST : WAIT;
            WAIT: begin
                if (tx_ready) begin
                    load         = 1'b1;
                    byte_idx_nxt = byte_idx + 4'd1;
                    state_nxt    = SEND;
                end
            end
            LAST: begin
                if (tx_ready) begin
                    done_nxt     = 1'b1;
                    byte_idx_nxt = 4'd0;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    uart_tx_byte #(
        .DIV(DIV)
    ) u_byte (
        .clock(CLOCK_50),
        .reset(RESET),
        .load (load),
        .data (load_byte),
        .tx   (TX),
        .ready(tx_ready)
    );

endmodule

// File: tb/tb_barcode_uart_tx.sv
// Scoreboard bench for barcode_uart_tx: expected frame bytes are queued at Start, a UART
// receiver monitor decodes TX and compares; a frame monitor checks Busy length and Done.
module tb_barcode_uart_tx;

    localparam int CLK_HZ = 1_050_000;
    localparam int BAUD   = 100_000;
    localparam int DIV    = CLK_HZ / BAUD;
`ifdef BARCODE_TX_CHECKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int FRAME_CYC = NB * 10 * DIV;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] d0, d1, d2, d3, qty;
    logic       tx, busy, done;

    always #5 clk = ~clk;

    barcode_uart_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) dut (
        .CLOCK_50       (clk),
        .RESET          (rst),
        .Start          (start),
        .Barcode_Digit_0(d0),
        .Barcode_Digit_1(d1),
        .Barcode_Digit_2(d2),
        .Barcode_Digit_3(d3),
        .ProductQuantity(qty),
        .TX             (tx),
        .Busy           (busy),
        .Done           (done)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];
    int         frames_expected = 0;
    int         done_count = 0;
    int         cycle = 0;
    int         rise_cycle = 0;
    int         fall_cycle = 0;

    function automatic logic [7:0] hex_ch(input logic [3:0] v);
        string s;
        s = "0123456789ABCDEF";
        return s[int'(v)];
    endfunction

    function automatic logic [7:0] dig_ch(input logic [3:0] d);
        return (d < 10) ? hex_ch(d) : "?";
    endfunction

    task automatic push_frame(input logic [3:0] a3, a2, a1, a0, q);
        exp_q.push_back("B");
        exp_q.push_back(dig_ch(a3));
        exp_q.push_back(dig_ch(a2));
        exp_q.push_back(dig_ch(a1));
        exp_q.push_back(dig_ch(a0));
        exp_q.push_back("x");
        exp_q.push_back(hex_ch(q));
`ifdef BARCODE_TX_CHECKSUM_EN
        exp_q.push_back(hex_ch(a3 ^ a2 ^ a1 ^ a0 ^ q));
`endif
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
        frames_expected++;
    endtask

    task automatic check(input string name, input int actual, input int required);
        vectors++;
        if (actual != required) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // UART receiver: samples mid-bit, decodes 10-bit symbols and pops the scoreboard.
    int         rx_active = 0;
    int         rx_cnt = 0;
    int         rx_bi = 0;
    logic [9:0] rx_bits;
    logic [7:0] exp_b;
    always @(negedge clk) begin
        if (rst) begin
            rx_active = 0;
        end else if (rx_active == 0) begin
            if (tx == 1'b0) begin
                rx_active = 1;
                rx_cnt    = 0;
                rx_bi     = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt == rx_bi * DIV + DIV / 2) begin
                rx_bits[rx_bi] = tx;
                rx_bi++;
                if (rx_bi == 10) begin
                    rx_active = 0;
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL rx_byte: unexpected symbol %03h, no byte queued", rx_bits);
                    end else begin
                        exp_b = exp_q.pop_front();
                        if (rx_bits != {1'b1, exp_b, 1'b0}) begin
                            miscompares++;
                            $display("FAIL rx_byte: got symbol %03h, expected %03h",
                                     rx_bits, {1'b1, exp_b, 1'b0});
                        end
                    end
                end
            end
        end
    end

    // Frame monitor: start bit coincides with Busy rising, Busy length, Done only at the end.
    logic busy_q = 1'b0;
    int   busy_run = 0;
    always @(negedge clk) begin
        cycle++;
        if (busy && !busy_q) begin
            rise_cycle = cycle;
            busy_run   = 0;
            check("start_bit_at_busy_rise", int'(tx), 0);
        end
        if (busy) busy_run++;
        if (!busy && busy_q) begin
            fall_cycle = cycle;
            if (rst) begin
                check("abort_no_done", int'(done), 0);
            end else begin
                check("busy_length", busy_run, FRAME_CYC);
                check("done_at_busy_fall", int'(done), 1);
            end
        end else if (done) begin
            check("stray_done", 1, 0);
        end
        if (done) done_count++;
        busy_q = busy;
    end

    task automatic send(input logic [3:0] a3, a2, a1, a0, q);
        @(posedge clk); #1;
        d3 = a3; d2 = a2; d1 = a1; d0 = a0; qty = q;
        start = 1'b1;
        push_frame(a3, a2, a1, a0, q);
        @(posedge clk); #1;
        start = 1'b0;
        {d3, d2, d1, d0, qty} = 20'($urandom);
    endtask

    task automatic wait_frame();
        int n;
        n = 0;
        while (busy && n < FRAME_CYC + 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            check("frame_timeout", 1, 0);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int fall_a;
        int n;
        rst = 1'b1; start = 1'b0;
        d0 = 4'd0; d1 = 4'd0; d2 = 4'd0; d3 = 4'd0; qty = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_tx", int'(tx), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);

        // Nominal frame.
        send(4'd1, 4'd2, 4'd3, 4'd4, 4'd5);
        wait_frame();

        // Non-BCD digit and hex-letter quantity.
        send(4'd7, 4'hA, 4'd0, 4'd9, 4'hC);
        wait_frame();

        // Start while busy is ignored and the latched data stays put.
        send(4'd8, 4'd6, 4'd4, 4'd2, 4'd1);
        repeat (100) @(posedge clk);
        #1;
        d3 = 4'd9; d2 = 4'd9; d1 = 4'd9; d0 = 4'd9; qty = 4'hF;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_frame();

        // Reset mid-frame abandons it; the next frame is complete.
        send(4'd3, 4'd1, 4'd4, 4'd1, 4'd5);
        repeat (500) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midreset_tx", int'(tx), 1);
        check("midreset_busy", int'(busy), 0);
        exp_q.delete();
        frames_expected--;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        send(4'd5, 4'd0, 4'd0, 4'd2, 4'd7);
        wait_frame();

        // Start in the Done cycle begins the next frame immediately.
        send(4'd2, 4'd4, 4'd6, 4'd8, 4'hE);
        n = 0;
        while (!done && n < FRAME_CYC + 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("done_seen", int'(done), 1);
        d3 = 4'd1; d2 = 4'd3; d1 = 4'd5; d0 = 4'd7; qty = 4'd9;
        start = 1'b1;
        push_frame(4'd1, 4'd3, 4'd5, 4'd7, 4'd9);
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        fall_a = fall_cycle;
        check("back_to_back_gap", rise_cycle - fall_a, 1);
        wait_frame();

        // Randomised frames over the full 4-bit input range.
        for (int i = 0; i < 4; i++) begin
            send(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom));
            wait_frame();
        end

        check("bytes_left_in_queue", exp_q.size(), 0);
        check("done_count", done_count, frames_expected);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/barcode_uart_tx.md
BARCODE_UART_TX -- requirements
Module: barcode_uart_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50000000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; DIV = CLK_HZ/BAUD, truncated (434 at defaults).
REQ-003 SHALL have port CLOCK_50  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port Start  input  1  one-cycle request to transmit one frame.
REQ-006 SHALL have ports Barcode_Digit_0..Barcode_Digit_3  input  4 each  BCD digits; digit 3 is most significant.
REQ-007 SHALL have port ProductQuantity  input  4  quantity, 0-15.
REQ-008 SHALL have port TX  output  1  UART line, 8N1, idle high.
REQ-009 SHALL have port Busy  output  1  high while a frame is in flight.
REQ-010 SHALL have port Done  output  1  one-cycle pulse when a frame completes.

Function
REQ-011 SHALL accept Start only while Busy=0, latching all digits and the quantity in that cycle; Busy SHALL rise the next cycle.
REQ-012 SHALL ignore Start while Busy=1, without queuing and without altering the latched data.
REQ-013 SHALL send frame bytes in order: 'B'(0x42), ASCII D3, D2, D1, D0, 'x'(0x78), Q, CR(0x0D), LF(0x0A).
REQ-014 SHALL encode a digit 0-9 as 0x30+d and a digit 10-15 as '?'(0x3F).
REQ-015 SHALL encode Q as an uppercase hex character: 0-9 to 0x30-0x39, 10-15 to 0x41-0x46.
REQ-016 SHALL frame each byte as start bit 0, 8 data bits LSB first, stop bit 1, each bit held exactly DIV cycles.
REQ-017 SHALL drive the start bit of byte 0 in the cycle Busy rises, and SHALL send all bytes back-to-back with no idle gap.
REQ-018 SHALL pulse Done and drop Busy in the cycle after the final stop bit's last cycle; total Busy time = bytes*10*DIV cycles.
REQ-019 SHALL accept a Start arriving in the Done cycle and begin a new frame the next cycle.
REQ-020 SHALL use top FSM states IDLE, SEND (byte issued to sub-module), WAIT (byte in flight), LAST (byte index = final byte, wait, then Done); byte index SHALL be a 4-bit counter that never wraps within a frame.
REQ-021 SHALL hold TX=1 whenever not transmitting.

Reset
REQ-022 SHALL, while RESET=1 asynchronously, force TX=1, Busy=0, Done=0, FSM=IDLE, byte index=0, and clear the bit and baud counters.
REQ-023 SHALL, on reset asserted mid-frame, abandon the frame without Done; the next accepted Start SHALL send a complete fresh frame.

Configuration
REQ-024 SHALL, with BARCODE_TX_CHECKSUM_EN defined, insert before CR one hex character (REQ-015 encoding) of D3^D2^D1^D0^Q, making 10 bytes.
REQ-025 SHALL, without BARCODE_TX_CHECKSUM_EN, send the 9-byte frame exactly as specified in REQ-013.

Structure
REQ-026 SHALL place ASCII constants (B, x, CR, LF, ?), FSM state typedef and frame-length constants in shared package sale_terminal_pkg.
REQ-027 SHALL instantiate one sub-module uart_tx_byte (ports: clock, reset, load, data[7:0], tx, ready) implementing REQ-016 baud and bit counting.

Verification
REQ-028 SHALL check: digits 1,2,3,4, Q=5, Start -> TX bytes 42 31 32 33 34 78 35 0D 0A; Busy high 39060 cycles; one Done.
REQ-029 SHALL check: D2=0xA, Q=0xC -> byte 3 = 0x3F, byte 7 = 0x43.
REQ-030 SHALL check: a second Start 1000 cycles into a frame with changed digits -> frame unchanged, exactly one Done.
REQ-031 SHALL check: RESET pulsed at cycle 5000 of a frame -> TX=1 and Busy=0 within the reset cycle, no Done; the next Start yields a full correct frame.
REQ-032 SHALL check: Start asserted in the Done cycle -> the next frame's start bit follows the next cycle, no idle gap.
REQ-033 SHALL check: with BARCODE_TX_CHECKSUM_EN, 1,2,3,4, Q=5 -> byte 8 = 0x31, 10 bytes, Busy 43400 cycles.
